// File: rtl/rename_map_table.sv
// rename_map_table: N-wide rename map (data, rename tag, renamed bit per arch register)
// with a circular FIFO of branch checkpoints. Define COMMIT_BYPASS_EN to forward commit data to same-cycle reads.
module rename_map_table #(
  parameter int ARCH_REGS = 32,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 6,
  parameter int RN_W      = 2,
  parameter int CM_W      = 2,
  parameter int CKPT_N    = 4,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int CW = $clog2(CKPT_N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [RN_W*AW-1:0]     rn_rs1_addr,
  input  logic [RN_W*AW-1:0]     rn_rs2_addr,
  output logic [RN_W*DATA_W-1:0] rn_rs1_data,
  output logic [RN_W*DATA_W-1:0] rn_rs2_data,
  output logic [RN_W*TAG_W-1:0]  rn_rs1_tag,
  output logic [RN_W*TAG_W-1:0]  rn_rs2_tag,
  output logic [RN_W-1:0]        rn_rs1_renamed,
  output logic [RN_W-1:0]        rn_rs2_renamed,
  input  logic [RN_W-1:0]        rn_we,
  input  logic [RN_W*AW-1:0]     rn_rd,
  input  logic [RN_W*TAG_W-1:0]  rn_tag,
  input  logic [CM_W-1:0]        cm_we,
  input  logic [CM_W*AW-1:0]     cm_rd,
  input  logic [CM_W*TAG_W-1:0]  cm_tag,
  input  logic [CM_W*DATA_W-1:0] cm_data,
  input  logic                   ckpt_take,
  output logic [CW-1:0]          ckpt_id,
  output logic                   ckpt_full,
  input  logic                   ckpt_release,
  input  logic                   ckpt_restore,
  input  logic [CW-1:0]          ckpt_restore_id
);

  localparam logic [CW:0] FULL_CNT = (CW+1)'(CKPT_N);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              ren;
  } rd_res_t;

  logic [DATA_W-1:0]    data_q   [ARCH_REGS];
  logic [TAG_W-1:0]     tag_q    [ARCH_REGS];
  logic [ARCH_REGS-1:0] ren_q;
  logic [TAG_W-1:0]     snap_tag [CKPT_N][ARCH_REGS];
  logic [ARCH_REGS-1:0] snap_ren [CKPT_N];
  logic [CW-1:0]        head, tail;
  logic [CW:0]          count;

  logic [DATA_W-1:0]    data_d   [ARCH_REGS];
  logic [TAG_W-1:0]     tag_d    [ARCH_REGS];
  logic [TAG_W-1:0]     tag_upd  [ARCH_REGS];
  logic [ARCH_REGS-1:0] ren_d, ren_upd, rn_hit, cm_clr;
  logic [ARCH_REGS-1:0] snap_clr [CKPT_N];
  logic [CW-1:0]        head_d, tail_d, head_rel, restore_off;
  logic [CW:0]          count_d, count_rel;
  logic                 rel_ok, take_ok, restore_ok;

  // Youngest earlier rename slot beats the (optional) commit bypass, which beats stored state.
  function automatic rd_res_t lookup(input logic [AW-1:0] a, input int slot);
    rd_res_t r;
    r.data = data_q[a];
    r.tag  = tag_q[a];
    r.ren  = ren_q[a];
`ifdef COMMIT_BYPASS_EN
    for (int p = 0; p < CM_W; p++) begin
      if (cm_we[p] && cm_rd[p*AW +: AW] == a) begin
        r.data = cm_data[p*DATA_W +: DATA_W];
        r.ren  = (tag_q[a] == cm_tag[p*TAG_W +: TAG_W]) ? 1'b0 : ren_q[a];
      end
    end
`endif
    for (int i = 0; i < RN_W; i++) begin
      if (i < slot && rn_we[i] && rn_rd[i*AW +: AW] == a) begin
        r.data = data_q[a];
        r.tag  = rn_tag[i*TAG_W +: TAG_W];
        r.ren  = 1'b1;
      end
    end
    if (a == '0) r = '0;
    return r;
  endfunction

  always_comb begin
    rd_res_t r1, r2;
    rn_rs1_data    = '0;
    rn_rs2_data    = '0;
    rn_rs1_tag     = '0;
    rn_rs2_tag     = '0;
    rn_rs1_renamed = '0;
    rn_rs2_renamed = '0;
    for (int j = 0; j < RN_W; j++) begin
      r1 = lookup(rn_rs1_addr[j*AW +: AW], j);
      r2 = lookup(rn_rs2_addr[j*AW +: AW], j);
      rn_rs1_data[j*DATA_W +: DATA_W] = r1.data;
      rn_rs2_data[j*DATA_W +: DATA_W] = r2.data;
      rn_rs1_tag[j*TAG_W +: TAG_W]    = r1.tag;
      rn_rs2_tag[j*TAG_W +: TAG_W]    = r2.tag;
      rn_rs1_renamed[j]               = r1.ren;
      rn_rs2_renamed[j]               = r2.ren;
    end
  end

  // Commit writes and tag-matched clears (live map and every snapshot), then renames.
  always_comb begin
    logic [AW-1:0]    a;
    logic [TAG_W-1:0] t;
    a       = '0;
    t       = '0;
    data_d  = data_q;
    cm_clr  = '0;
    for (int k = 0; k < CKPT_N; k++) snap_clr[k] = '0;
    for (int p = 0; p < CM_W; p++) begin
      a = cm_rd[p*AW +: AW];
      t = cm_tag[p*TAG_W +: TAG_W];
      if (cm_we[p] && a != '0) begin
        data_d[a] = cm_data[p*DATA_W +: DATA_W];
        cm_clr[a] = (tag_q[a] == t);
        for (int k = 0; k < CKPT_N; k++) snap_clr[k][a] = (snap_tag[k][a] == t);
      end
    end

    rn_hit  = '0;
    tag_upd = tag_q;
    for (int i = 0; i < RN_W; i++) begin
      a = rn_rd[i*AW +: AW];
      if (rn_we[i] && a != '0) begin
        rn_hit[a]  = 1'b1;
        tag_upd[a] = rn_tag[i*TAG_W +: TAG_W];
      end
    end
    ren_upd = rn_hit | (ren_q & ~cm_clr);

    if (flush) begin
      tag_d = tag_q;
      ren_d = '0;
    end else if (ckpt_restore) begin
      tag_d = snap_tag[ckpt_restore_id];
      ren_d = snap_ren[ckpt_restore_id] & ~snap_clr[ckpt_restore_id];
    end else begin
      tag_d = tag_upd;
      ren_d = ren_upd;
    end
  end

  // Release is applied before restore so a restore sees the post-release head.
  always_comb begin
    rel_ok      = ckpt_release && (count != '0);
    head_rel    = head + CW'(rel_ok);
    count_rel   = count - (CW+1)'(rel_ok);
    take_ok     = ckpt_take && (count != FULL_CNT) && !ckpt_restore && !flush;
    restore_off = ckpt_restore_id - head_rel;
    restore_ok  = ({1'b0, restore_off} < count_rel);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (ckpt_restore) begin
      head_d  = head_rel;
      tail_d  = ckpt_restore_id;
      count_d = {1'b0, restore_off};
    end else begin
      head_d  = head_rel;
      tail_d  = tail + CW'(take_ok);
      count_d = count_rel + (CW+1)'(take_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ARCH_REGS; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      ren_q <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int k = 0; k < CKPT_N; k++) begin
        snap_ren[k] <= '0;
        for (int r = 0; r < ARCH_REGS; r++) snap_tag[k][r] <= '0;
      end
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      ren_q  <= ren_d;
      head   <= head_d;
      tail   <= tail_d;
      count  <= count_d;
      for (int k = 0; k < CKPT_N; k++) begin
        if (flush) begin
          snap_ren[k] <= '0;
        end else if (take_ok && tail == CW'(k)) begin
          snap_tag[k] <= tag_upd;
          snap_ren[k] <= ren_upd;
        end else begin
          snap_ren[k] <= snap_ren[k] & ~snap_clr[k];
        end
      end
    end
  end

  assign ckpt_id   = tail;
  assign ckpt_full = (count == FULL_CNT);

  a_restore_valid: assert property (@(posedge clk) disable iff (!rst)
    (ckpt_restore && !flush) |-> restore_ok);

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the map and its checkpoints.
`timescale 1ns/1ps
module tb_rename_map_table;
  localparam int AR = 32, DW = 32, TW = 6, RW = 2, CP = 2, CN = 4, AW = 5, CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush;
  logic [RW*AW-1:0] rn_rs1_addr, rn_rs2_addr, rn_rd;
  logic [RW*DW-1:0] rn_rs1_data, rn_rs2_data;
  logic [RW*TW-1:0] rn_rs1_tag, rn_rs2_tag, rn_tag;
  logic [RW-1:0]    rn_rs1_renamed, rn_rs2_renamed, rn_we;
  logic [CP-1:0]    cm_we;
  logic [CP*AW-1:0] cm_rd;
  logic [CP*TW-1:0] cm_tag;
  logic [CP*DW-1:0] cm_data;
  logic             ckpt_take, ckpt_full, ckpt_release, ckpt_restore;
  logic [CW-1:0]    ckpt_id, ckpt_restore_id;

  always #5 clk = ~clk;

  rename_map_table #(.ARCH_REGS(AR), .DATA_W(DW), .TAG_W(TW), .RN_W(RW), .CM_W(CP), .CKPT_N(CN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rn_rs1_addr(rn_rs1_addr), .rn_rs2_addr(rn_rs2_addr),
    .rn_rs1_data(rn_rs1_data), .rn_rs2_data(rn_rs2_data),
    .rn_rs1_tag(rn_rs1_tag), .rn_rs2_tag(rn_rs2_tag),
    .rn_rs1_renamed(rn_rs1_renamed), .rn_rs2_renamed(rn_rs2_renamed),
    .rn_we(rn_we), .rn_rd(rn_rd), .rn_tag(rn_tag),
    .cm_we(cm_we), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_release(ckpt_release), .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: live map plus an ordered list of outstanding checkpoints.
  typedef struct packed {
    logic [CW-1:0]    id;
    logic [AR*TW-1:0] tags;
    logic [AR-1:0]    ren;
  } snap_t;

  logic [DW-1:0] m_data [AR];
  logic [TW-1:0] m_tag  [AR];
  logic [AR-1:0] m_ren;
  snap_t         snaps [$];
  int            m_tail;

  function automatic void model_reset();
    for (int r = 0; r < AR; r++) begin
      m_data[r] = '0;
      m_tag[r]  = '0;
    end
    m_ren = '0;
    snaps.delete();
    m_tail = 0;
  endfunction

  function automatic void model_tick();
    int cm_last [AR];
    int rn_last [AR];
    int sz0, idx;
    snap_t e;
    for (int r = 0; r < AR; r++) begin
      cm_last[r] = -1;
      rn_last[r] = -1;
    end
    for (int p = 0; p < CP; p++)
      if (cm_we[p] && cm_rd[p*AW +: AW] != 0) cm_last[cm_rd[p*AW +: AW]] = p;
    for (int i = 0; i < RW; i++)
      if (rn_we[i] && rn_rd[i*AW +: AW] != 0) rn_last[rn_rd[i*AW +: AW]] = i;
    sz0 = snaps.size();
    for (int k = 0; k < snaps.size(); k++) begin
      e = snaps[k];
      for (int r = 0; r < AR; r++)
        if (cm_last[r] >= 0 && e.tags[r*TW +: TW] == cm_tag[cm_last[r]*TW +: TW]) e.ren[r] = 1'b0;
      snaps[k] = e;
    end
    for (int r = 0; r < AR; r++)
      if (cm_last[r] >= 0) m_data[r] = cm_data[cm_last[r]*DW +: DW];
    if (flush) begin
      m_ren = '0;
      snaps.delete();
      m_tail = 0;
      return;
    end
    if (ckpt_release && snaps.size() > 0) void'(snaps.pop_front());
    if (ckpt_restore) begin
      idx = -1;
      for (int k = 0; k < snaps.size(); k++) if (snaps[k].id == ckpt_restore_id) idx = k;
      if (idx >= 0) begin
        e = snaps[idx];
        for (int r = 0; r < AR; r++) m_tag[r] = e.tags[r*TW +: TW];
        m_ren = e.ren;
        while (snaps.size() > idx) void'(snaps.pop_back());
      end
      m_tail = int'(ckpt_restore_id);
    end else begin
      for (int r = 0; r < AR; r++) begin
        if (rn_last[r] >= 0) begin
          m_tag[r] = rn_tag[rn_last[r]*TW +: TW];
          m_ren[r] = 1'b1;
        end else if (cm_last[r] >= 0 && m_tag[r] == cm_tag[cm_last[r]*TW +: TW]) begin
          m_ren[r] = 1'b0;
        end
      end
      if (ckpt_take && sz0 < CN) begin
        e.id = CW'(m_tail);
        for (int r = 0; r < AR; r++) e.tags[r*TW +: TW] = m_tag[r];
        e.ren = m_ren;
        snaps.push_back(e);
        m_tail = (m_tail + 1) % CN;
      end
    end
  endfunction

  function automatic void model_read(input int s, input logic [AW-1:0] a,
                                     output logic [DW-1:0] d, output logic [TW-1:0] t, output logic r);
    int ih;
    d = m_data[a];
    t = m_tag[a];
    r = m_ren[a];
    if (a == 0) begin
      d = '0; t = '0; r = 1'b0;
      return;
    end
    ih = -1;
    for (int i = s - 1; i >= 0; i--)
      if (ih < 0 && rn_we[i] && rn_rd[i*AW +: AW] == a) ih = i;
    if (ih >= 0) begin
      t = rn_tag[ih*TW +: TW];
      r = 1'b1;
      return;
    end
`ifdef COMMIT_BYPASS_EN
    begin
      int ph;
      ph = -1;
      for (int p = CP - 1; p >= 0; p--)
        if (ph < 0 && cm_we[p] && cm_rd[p*AW +: AW] == a) ph = p;
      if (ph >= 0) begin
        d = cm_data[ph*DW +: DW];
        if (m_tag[a] == cm_tag[ph*TW +: TW]) r = 1'b0;
      end
    end
`endif
  endfunction

  task automatic clear_inputs();
    flush = 0; rn_rs1_addr = '0; rn_rs2_addr = '0; rn_we = '0; rn_rd = '0; rn_tag = '0;
    cm_we = '0; cm_rd = '0; cm_tag = '0; cm_data = '0;
    ckpt_take = 0; ckpt_release = 0; ckpt_restore = 0; ckpt_restore_id = '0;
  endtask

  task automatic set_src(input int s, input int a1, input int a2);
    rn_rs1_addr[s*AW +: AW] = AW'(a1);
    rn_rs2_addr[s*AW +: AW] = AW'(a2);
  endtask

  task automatic set_rn(input int s, input int rd, input int tag);
    rn_we[s] = 1'b1;
    rn_rd[s*AW +: AW] = AW'(rd);
    rn_tag[s*TW +: TW] = TW'(tag);
  endtask

  task automatic set_cm(input int p, input int rd, input int tag, input logic [DW-1:0] d);
    cm_we[p] = 1'b1;
    cm_rd[p*AW +: AW] = AW'(rd);
    cm_tag[p*TW +: TW] = TW'(tag);
    cm_data[p*DW +: DW] = d;
  endtask

  task automatic cycle();
    model_tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs(); set_src(0, 5, 0); #1;
    checks++; if (rn_rs1_data[DW-1:0] !== '0) begin failures++; $display("FAIL reset_data got=%0h want=0", rn_rs1_data[DW-1:0]); end
    checks++; if (rn_rs1_tag[TW-1:0] !== '0) begin failures++; $display("FAIL reset_tag got=%0d want=0", rn_rs1_tag[TW-1:0]); end
    checks++; if (rn_rs1_renamed[0] !== 1'b0) begin failures++; $display("FAIL reset_renamed got=%0b want=0", rn_rs1_renamed[0]); end
    checks++; if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin failures++; $display("FAIL reset_ckpt got id=%0d full=%0b want id=0 full=0", ckpt_id, ckpt_full); end
  endtask

  task automatic test_rename_basic();
    clear_inputs(); set_rn(0, 5, 3); cycle();
    clear_inputs(); set_src(0, 5, 0); #1;
    checks++; if (rn_rs1_tag[TW-1:0] !== 6'd3 || rn_rs1_renamed[0] !== 1'b1) begin failures++; $display("FAIL rename_x5 got tag=%0d ren=%0b want tag=3 ren=1", rn_rs1_tag[TW-1:0], rn_rs1_renamed[0]); end
    checks++; if (rn_rs2_tag[TW-1:0] !== '0 || rn_rs2_renamed[0] !== 1'b0) begin failures++; $display("FAIL read_x0 got tag=%0d ren=%0b want 0 0", rn_rs2_tag[TW-1:0], rn_rs2_renamed[0]); end
  endtask

  task automatic test_bundle_bypass();
    clear_inputs(); set_rn(0, 7, 10); set_src(0, 7, 0); set_src(1, 7, 0); #1;
    checks++; if (rn_rs1_tag[TW +: TW] !== 6'd10 || rn_rs1_renamed[1] !== 1'b1) begin failures++; $display("FAIL bundle_bypass got tag=%0d ren=%0b want tag=10 ren=1", rn_rs1_tag[TW +: TW], rn_rs1_renamed[1]); end
    checks++; if (rn_rs1_renamed[0] !== 1'b0) begin failures++; $display("FAIL slot0_no_self_bypass got ren=%0b want 0", rn_rs1_renamed[0]); end
    set_rn(1, 7, 11); #1;
    checks++; if (rn_rs1_tag[TW +: TW] !== 6'd10) begin failures++; $display("FAIL own_slot_ignored got tag=%0d want 10", rn_rs1_tag[TW +: TW]); end
    cycle();
    clear_inputs(); set_src(0, 7, 0); #1;
    checks++; if (rn_rs1_tag[TW-1:0] !== 6'd11 || rn_rs1_renamed[0] !== 1'b1) begin failures++; $display("FAIL same_rd_highest_slot got tag=%0d ren=%0b want tag=11 ren=1", rn_rs1_tag[TW-1:0], rn_rs1_renamed[0]); end
  endtask

  task automatic test_commit();
    clear_inputs(); set_rn(0, 4, 2); cycle();
    clear_inputs(); set_cm(0, 4, 2, 32'hAB); cycle();
    clear_inputs(); set_src(0, 4, 0); #1;
    checks++; if (rn_rs1_data[DW-1:0] !== 32'hAB || rn_rs1_renamed[0] !== 1'b0) begin failures++; $display("FAIL commit_match got data=%0h ren=%0b want data=ab ren=0", rn_rs1_data[DW-1:0], rn_rs1_renamed[0]); end
    set_rn(0, 4, 6); cycle();
    clear_inputs(); set_cm(0, 4, 1, 32'hCD); cycle();
    clear_inputs(); set_src(0, 4, 0); #1;
    checks++; if (rn_rs1_data[DW-1:0] !== 32'hCD || rn_rs1_renamed[0] !== 1'b1 || rn_rs1_tag[TW-1:0] !== 6'd6) begin failures++; $display("FAIL commit_stale got data=%0h ren=%0b tag=%0d want cd 1 6", rn_rs1_data[DW-1:0], rn_rs1_renamed[0], rn_rs1_tag[TW-1:0]); end
    set_rn(0, 4, 9); set_cm(0, 4, 6, 32'h1); cycle();
    clear_inputs(); set_src(0, 4, 0); #1;
    checks++; if (rn_rs1_tag[TW-1:0] !== 6'd9 || rn_rs1_renamed[0] !== 1'b1) begin failures++; $display("FAIL rename_beats_commit got tag=%0d ren=%0b want 9 1", rn_rs1_tag[TW-1:0], rn_rs1_renamed[0]); end
    set_cm(0, 4, 9, 32'h11); set_cm(1, 4, 3, 32'h22); cycle();
    clear_inputs(); set_src(0, 4, 0); #1;
    checks++; if (rn_rs1_data[DW-1:0] !== 32'h22 || rn_rs1_renamed[0] !== 1'b1) begin failures++; $display("FAIL commit_high_port_stale got data=%0h ren=%0b want 22 1", rn_rs1_data[DW-1:0], rn_rs1_renamed[0]); end
    set_cm(0, 4, 3, 32'h33); set_cm(1, 4, 9, 32'h44); cycle();
    clear_inputs(); set_src(0, 4, 0); #1;
    checks++; if (rn_rs1_data[DW-1:0] !== 32'h44 || rn_rs1_renamed[0] !== 1'b0) begin failures++; $display("FAIL commit_high_port_match got data=%0h ren=%0b want 44 0", rn_rs1_data[DW-1:0], rn_rs1_renamed[0]); end
  endtask

  task automatic test_checkpoint_full();
    clear_inputs(); ckpt_take = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(); #1;
      checks++; if (ckpt_id !== CW'(i + 1) || ckpt_full !== (i == 3)) begin failures++; $display("FAIL take_%0d got id=%0d full=%0b want id=%0d full=%0b", i, ckpt_id, ckpt_full, (i + 1) % CN, i == 3); end
    end
    cycle(); #1;
    checks++; if (ckpt_id !== 2'd0 || ckpt_full !== 1'b1) begin failures++; $display("FAIL take_when_full got id=%0d full=%0b want 0 1", ckpt_id, ckpt_full); end
    clear_inputs(); ckpt_release = 1; cycle(); #1;
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL release_unfull got full=%0b want 0", ckpt_full); end
    clear_inputs(); ckpt_take = 1; cycle(); #1;
    checks++; if (ckpt_id !== 2'd1 || ckpt_full !== 1'b1) begin failures++; $display("FAIL take_after_release got id=%0d full=%0b want 1 1", ckpt_id, ckpt_full); end
    clear_inputs(); ckpt_release = 1;
    for (int i = 0; i < 5; i++) cycle();
    clear_inputs(); ckpt_take = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(); #1;
      checks++; if (ckpt_full !== (i == 3)) begin failures++; $display("FAIL refill_%0d got full=%0b want %0b", i, ckpt_full, i == 3); end
    end
    clear_inputs(); flush = 1; cycle();
    clear_inputs(); set_src(0, 7, 0); #1;
    checks++; if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0 || rn_rs1_renamed[0] !== 1'b0) begin failures++; $display("FAIL flush got id=%0d full=%0b ren=%0b want 0 0 0", ckpt_id, ckpt_full, rn_rs1_renamed[0]); end
  endtask

  task automatic test_restore();
    clear_inputs(); set_rn(0, 9, 5); cycle();
    clear_inputs(); ckpt_take = 1; cycle();
    clear_inputs(); set_rn(0, 9, 8); cycle();
    clear_inputs(); set_cm(0, 9, 5, 32'h99); cycle();
    clear_inputs(); set_src(0, 9, 0); #1;
    checks++; if (rn_rs1_tag[TW-1:0] !== 6'd8 || rn_rs1_renamed[0] !== 1'b1 || ckpt_id !== 2'd1) begin failures++; $display("FAIL pre_restore got tag=%0d ren=%0b id=%0d want 8 1 1", rn_rs1_tag[TW-1:0], rn_rs1_renamed[0], ckpt_id); end
    ckpt_restore = 1; ckpt_restore_id = 2'd0; cycle();
    clear_inputs(); set_src(0, 9, 0); #1;
    checks++; if (rn_rs1_tag[TW-1:0] !== 6'd5 || rn_rs1_renamed[0] !== 1'b0 || rn_rs1_data[DW-1:0] !== 32'h99) begin failures++; $display("FAIL restore_map got tag=%0d ren=%0b data=%0h want 5 0 99", rn_rs1_tag[TW-1:0], rn_rs1_renamed[0], rn_rs1_data[DW-1:0]); end
    checks++; if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin failures++; $display("FAIL restore_ptr got id=%0d full=%0b want 0 0", ckpt_id, ckpt_full); end
  endtask

  task automatic test_commit_visibility();
    clear_inputs(); set_cm(0, 3, 0, 32'h55); set_src(0, 3, 0); #1;
`ifdef COMMIT_BYPASS_EN
    checks++; if (rn_rs1_data[DW-1:0] !== 32'h55 || rn_rs1_renamed[0] !== 1'b0) begin failures++; $display("FAIL commit_bypass got data=%0h ren=%0b want 55 0", rn_rs1_data[DW-1:0], rn_rs1_renamed[0]); end
`else
    checks++; if (rn_rs1_data[DW-1:0] !== 32'h0) begin failures++; $display("FAIL commit_no_bypass got data=%0h want 0", rn_rs1_data[DW-1:0]); end
`endif
    cycle();
    clear_inputs(); set_src(0, 3, 0); #1;
    checks++; if (rn_rs1_data[DW-1:0] !== 32'h55) begin failures++; $display("FAIL commit_next_cycle got data=%0h want 55", rn_rs1_data[DW-1:0]); end
  endtask

  task automatic test_random();
    logic [DW-1:0] ed;
    logic [TW-1:0] et;
    logic          er;
    int            start, idx, ncyc;
    ncyc = 600;
    for (int n = 0; n < ncyc; n++) begin
      clear_inputs();
      for (int s = 0; s < RW; s++) begin
        set_src(s, $urandom_range(0, 7), $urandom_range(0, 7));
        rn_we[s] = 1'($urandom);
        rn_rd[s*AW +: AW] = AW'($urandom_range(0, 7));
        rn_tag[s*TW +: TW] = TW'($urandom);
      end
      for (int p = 0; p < CP; p++) begin
        cm_we[p] = 1'($urandom);
        cm_rd[p*AW +: AW] = AW'($urandom_range(0, 7));
        cm_tag[p*TW +: TW] = ($urandom_range(0, 1) == 1) ? m_tag[cm_rd[p*AW +: AW]] : TW'($urandom);
        cm_data[p*DW +: DW] = $urandom;
      end
      ckpt_take    = ($urandom_range(0, 2) == 0);
      ckpt_release = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 39) == 0);
      start = (ckpt_release && snaps.size() > 0) ? 1 : 0;
      if ($urandom_range(0, 5) == 0 && snaps.size() > start) begin
        idx = $urandom_range(start, snaps.size() - 1);
        ckpt_restore = 1;
        ckpt_restore_id = snaps[idx].id;
      end
      #1;
      for (int s = 0; s < RW; s++) begin
        model_read(s, rn_rs1_addr[s*AW +: AW], ed, et, er);
        checks++;
        if (rn_rs1_data[s*DW +: DW] !== ed || rn_rs1_tag[s*TW +: TW] !== et || rn_rs1_renamed[s] !== er) begin
          failures++;
          $display("FAIL rand_rs1 cyc=%0d slot=%0d got d=%0h t=%0d r=%0b want d=%0h t=%0d r=%0b", n, s, rn_rs1_data[s*DW +: DW], rn_rs1_tag[s*TW +: TW], rn_rs1_renamed[s], ed, et, er);
        end
        model_read(s, rn_rs2_addr[s*AW +: AW], ed, et, er);
        checks++;
        if (rn_rs2_data[s*DW +: DW] !== ed || rn_rs2_tag[s*TW +: TW] !== et || rn_rs2_renamed[s] !== er) begin
          failures++;
          $display("FAIL rand_rs2 cyc=%0d slot=%0d got d=%0h t=%0d r=%0b want d=%0h t=%0d r=%0b", n, s, rn_rs2_data[s*DW +: DW], rn_rs2_tag[s*TW +: TW], rn_rs2_renamed[s], ed, et, er);
        end
      end
      checks++;
      if (ckpt_id !== CW'(m_tail) || ckpt_full !== (snaps.size() == CN)) begin
        failures++;
        $display("FAIL rand_ckpt cyc=%0d got id=%0d full=%0b want id=%0d full=%0b", n, ckpt_id, ckpt_full, m_tail, snaps.size() == CN);
      end
      cycle();
    end
  endtask

  task automatic test_async_reset();
    clear_inputs(); set_rn(0, 5, 20); set_rn(1, 9, 21); ckpt_take = 1; cycle();
    clear_inputs(); set_rn(0, 5, 22); set_src(0, 5, 0); set_src(1, 9, 0); #1;
    checks++; if (rn_rs1_tag[TW-1:0] !== 6'd20 || rn_rs1_tag[TW +: TW] !== 6'd21) begin failures++; $display("FAIL pre_reset got t0=%0d t1=%0d want 20 21", rn_rs1_tag[TW-1:0], rn_rs1_tag[TW +: TW]); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rn_rs1_tag !== '0 || rn_rs1_renamed !== '0 || rn_rs1_data !== '0) begin failures++; $display("FAIL async_reset_reads got tag=%0h ren=%0b data=%0h want 0", rn_rs1_tag, rn_rs1_renamed, rn_rs1_data); end
    checks++; if (ckpt_id !== 2'd0 || ckpt_full !== 1'b0) begin failures++; $display("FAIL async_reset_ckpt got id=%0d full=%0b want 0 0", ckpt_id, ckpt_full); end
    model_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    cycle();
    set_src(0, 5, 9); #1;
    checks++; if (rn_rs1_tag[TW-1:0] !== '0 || rn_rs2_renamed[0] !== 1'b0) begin failures++; $display("FAIL post_reset got tag=%0d ren=%0b want 0 0", rn_rs1_tag[TW-1:0], rn_rs2_renamed[0]); end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_rename_basic();
    test_bundle_bypass();
    test_commit();
    test_checkpoint_full();
    test_restore();
    test_commit_visibility();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
